// File: rtl/contadores_pkg.sv
// Shared definitions for the Contadores counter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package contadores_pkg;

  // Default counter width used across the family.
  localparam int CONTADORES_WIDTH = 32;

  // Timer state encoding shared by the down- and up-counters.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/prescaler_tick.sv
// Enable divider: emits one tick on every PRESC-th cycle with en high.
// Latency: tick is combinational with en; the divider state advances on the clock edge.
// Backpressure: none; clr restarts the division phase synchronously.
//
// Ports: clk, rst (sync, active-high), clr (sync restart), en (raw enable),
//        tick (divided enable, same cycle as the en that completes a group).
// Only compiled when CONTADOR_DESCENDENTE_PRESCALER_EN is defined, because the
// only user instantiates it under that macro.
`ifdef CONTADOR_DESCENDENTE_PRESCALER_EN
module prescaler_tick #(
  parameter int WIDTH = 2,
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // PRESC of 1 gives LAST=0, so every enabled cycle is a tick.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(PRESC - 1);

  logic [WIDTH-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/contador_descendente_recarga.sv
// Reloadable down-counting timer with one-shot/periodic modes and sticky irq.
// Latency: start -> busy one cycle later; tc is combinational in the terminal cycle.
// Backpressure: none; ena gates counting, stop halts and holds the count.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   ena            count tick enable
//   load, d        write d into the reload register (and the count when not running)
//   start, stop    (re)start from the reload value / halt holding the count
//   periodic       auto-reload at terminal count when high, else one-shot
//   irq_ack        clear the sticky irq flag
//   tc             terminal-count pulse (combinational)
//   irq            sticky flag set by tc
//   busy, done     running / one-shot expired
//   cnt            current count
// Optional: CONTADOR_DESCENDENTE_PRESCALER_EN adds parameter PRESC and divides
// ena by PRESC while running.
module contador_descendente_recarga
  import contadores_pkg::*;
#(
  parameter int               WIDTH  = CONTADORES_WIDTH,
  parameter logic [WIDTH-1:0] RELOAD = '1,
  parameter logic [WIDTH-1:0] TO     = '0
`ifdef CONTADOR_DESCENDENTE_PRESCALER_EN
  , parameter int             PRESC  = 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             irq_ack,
  output logic             tc,
  output logic             irq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cnt
);

  cnt_state_t       state, state_nx;
  logic [WIDTH-1:0] r, r_nx;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_val;
  logic             run;
  logic             tick;

  assign run = (state == ST_RUN);

  // A load in the same cycle as a start/reload is used immediately.
  assign reload_val = load ? d : reload_r;

`ifdef CONTADOR_DESCENDENTE_PRESCALER_EN
  localparam int PW = $clog2(PRESC) + 1;

  // Divider only advances while running; start and stop realign its phase.
  prescaler_tick #(
    .WIDTH (PW),
    .PRESC (PRESC)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (start | stop),
    .en   (ena & run),
    .tick (tick)
  );
`else
  assign tick = ena;
`endif

  // stop and start both suppress the terminal event in their cycle.
  assign tc = run && tick && !stop && !start && (r == TO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    r_nx     = r;
    if (run && stop) begin
      // Halt, holding the count where it is.
      state_nx = ST_IDLE;
    end else if (start && !stop) begin
      state_nx = ST_RUN;
      r_nx     = reload_val;
    end else if (run) begin
      if (tick) begin
        if (r == TO) begin
          if (periodic) begin
            r_nx = reload_val;
          end else begin
            state_nx = ST_DONE;
          end
        end else begin
          // Wraps modulo 2^WIDTH when the reload value is below TO.
          r_nx = r - WIDTH'(1);
        end
      end
    end else if (load) begin
      // Not running: the count follows the reload register directly.
      r_nx = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r        <= RELOAD;
      reload_r <= RELOAD;
      irq      <= 1'b0;
    end else begin
      r <= r_nx;
      if (load) begin
        reload_r <= d;
      end
      // Setting wins over a simultaneous acknowledge.
      if (tc) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
    end
  end

  assign busy = run;
  assign done = (state == ST_DONE);
  assign cnt  = r;

endmodule

// File: tb/tb_contador_descendente_recarga.sv
`timescale 1ns/1ps
module tb_contador_descendente_recarga;

  localparam int W   = 4;
  localparam int MOD = 16;
`ifdef CONTADOR_DESCENDENTE_PRESCALER_EN
  localparam int NDUT    = 3;
  localparam int PRESC_T = 4;
`else
  localparam int NDUT    = 2;
  localparam int PRESC_T = 1;
`endif

  logic         clk = 1'b0;
  logic         rst, ena, load, start, stop, periodic, irq_ack;
  logic [W-1:0] d;

  logic         tc_o   [NDUT];
  logic         irq_o  [NDUT];
  logic         busy_o [NDUT];
  logic         done_o [NDUT];
  logic [W-1:0] cnt_o  [NDUT];
  logic         tc_p;

  int to_of    [NDUT];
  int presc_of [NDUT];

  // Reference model: plain booleans and modular integers.
  bit m_run [NDUT];
  bit m_exp [NDUT];
  bit m_irq [NDUT];
  int m_cnt [NDUT];
  int m_rel [NDUT];
  int m_pre [NDUT];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  contador_descendente_recarga #(.WIDTH(W), .RELOAD(4'hF), .TO(4'd0)) u_dut0 (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .d(d), .start(start), .stop(stop),
    .periodic(periodic), .irq_ack(irq_ack), .tc(tc_o[0]), .irq(irq_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .cnt(cnt_o[0]));

  contador_descendente_recarga #(.WIDTH(W), .RELOAD(4'hF), .TO(4'd5)) u_dut1 (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .d(d), .start(start), .stop(stop),
    .periodic(periodic), .irq_ack(irq_ack), .tc(tc_o[1]), .irq(irq_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .cnt(cnt_o[1]));

`ifdef CONTADOR_DESCENDENTE_PRESCALER_EN
  contador_descendente_recarga #(.WIDTH(W), .RELOAD(4'hF), .TO(4'd0), .PRESC(PRESC_T)) u_dut2 (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .d(d), .start(start), .stop(stop),
    .periodic(periodic), .irq_ack(irq_ack), .tc(tc_o[2]), .irq(irq_o[2]),
    .busy(busy_o[2]), .done(done_o[2]), .cnt(cnt_o[2]));
  assign tc_p = tc_o[2];
`else
  assign tc_p = tc_o[0];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // An effective tick happens on the enabled cycle that completes a prescale group.
  function automatic bit m_tick(input int i);
    return ena && m_run[i] && (m_pre[i] == presc_of[i] - 1);
  endfunction

  function automatic bit m_tc(input int i);
    return m_tick(i) && !stop && !start && (m_cnt[i] == to_of[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      bit tcv, tk;
      int nrel;
      tcv  = m_tc(i);
      tk   = m_tick(i);
      nrel = load ? int'(d) : m_rel[i];
      if (rst) begin
        m_cnt[i] = MOD - 1; m_rel[i] = MOD - 1;
        m_run[i] = 0; m_exp[i] = 0; m_irq[i] = 0; m_pre[i] = 0;
      end else begin
        if (tcv) m_irq[i] = 1;
        else if (irq_ack) m_irq[i] = 0;
        if (start || stop) m_pre[i] = 0;
        else if (ena && m_run[i]) m_pre[i] = (m_pre[i] + 1) % presc_of[i];
        if (m_run[i] && stop) begin
          m_run[i] = 0;
        end else if (start && !stop) begin
          m_cnt[i] = nrel; m_run[i] = 1; m_exp[i] = 0;
        end else if (m_run[i]) begin
          if (tk) begin
            if (m_cnt[i] != to_of[i]) m_cnt[i] = (m_cnt[i] + MOD - 1) % MOD;
            else if (periodic) m_cnt[i] = nrel;
            else begin m_run[i] = 0; m_exp[i] = 1; end
          end
        end else if (load) begin
          m_cnt[i] = int'(d);
        end
        m_rel[i] = nrel;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("model tc[%0d]", i),   32'(tc_o[i]),   32'(m_tc(i)));
        check($sformatf("model irq[%0d]", i),  32'(irq_o[i]),  32'(m_irq[i]));
        check($sformatf("model busy[%0d]", i), 32'(busy_o[i]), 32'(m_run[i]));
        check($sformatf("model done[%0d]", i), 32'(done_o[i]), 32'(m_exp[i]));
        check($sformatf("model cnt[%0d]", i),  32'(cnt_o[i]),  32'(m_cnt[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic l, input logic [W-1:0] dv,
                     input logic s, input logic sp, input logic p, input logic a);
    ena = e; load = l; d = dv; start = s; stop = sp; periodic = p; irq_ack = a;
  endtask

  initial begin
    int pulses, gap, first, second;
    to_of[0] = 0; to_of[1] = 5;
    presc_of[0] = 1; presc_of[1] = 1;
`ifdef CONTADOR_DESCENDENTE_PRESCALER_EN
    to_of[2] = 0; presc_of[2] = PRESC_T;
`endif
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset values.
    @(negedge clk);
    check("reset cnt", 32'(cnt_o[0]), 15);
    check("reset busy", 32'(busy_o[0]), 0);
    check("reset done", 32'(done_o[0]), 0);
    check("reset irq", 32'(irq_o[0]), 0);
    check("reset tc", 32'(tc_p), 0);
    step();

    // One-shot from 3.
    drv(1, 1, 3, 1, 0, 0, 0); step();
    for (int k = 0; k < 4; k++) begin
      drv(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("oneshot cnt", 32'(cnt_o[0]), 32'(3 - k));
      check("oneshot tc", 32'(tc_o[0]), 32'(k == 3));
      step();
    end
    drv(1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("oneshot done", 32'(done_o[0]), 1);
    check("oneshot hold", 32'(cnt_o[0]), 0);
    check("oneshot irq", 32'(irq_o[0]), 1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("irq ack", 32'(irq_o[0]), 0);
    step();

    // Periodic from 2, then shadow reload of 5.
    drv(1, 1, 2, 1, 0, 1, 0); step();
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      drv(1, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      if (tc_o[0]) pulses++;
      step();
    end
    check("periodic pulses", 32'(pulses), 3);
    drv(1, 1, 5, 0, 0, 1, 0);
    @(negedge clk);
    check("shadow cnt0", 32'(cnt_o[0]), 2);
    step();
    drv(1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("shadow cnt1", 32'(cnt_o[0]), 1);
    step();
    @(negedge clk);
    check("shadow tc", 32'(tc_o[0]), 1);
    step();
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      gap++;
      if (tc_o[0]) begin step(); break; end
      step();
    end
    check("new period", 32'(gap), 6);

    // stop in the terminal cycle.
    drv(1, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cnt_o[0] == 4'd1) begin step(); break; end
      step();
    end
    drv(1, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    check("stop tc", 32'(tc_o[0]), 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("stop busy", 32'(busy_o[0]), 0);
    check("stop cnt", 32'(cnt_o[0]), 0);
    check("stop irq", 32'(irq_o[0]), 0);
    step();

    // tc and irq_ack together.
    drv(1, 1, 1, 1, 0, 0, 0); step();
    drv(1, 0, 0, 0, 0, 0, 0); step();
    drv(1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("ack tc", 32'(tc_o[0]), 1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("ack loses", 32'(irq_o[0]), 1);
    step();

    // TO=5 with reload 2: wraps through 15, with an ena=0 hold.
    drv(1, 1, 2, 1, 0, 0, 0); step();
    for (int k = 0; k < 14; k++) begin
      if (k == 4) begin
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("hold cnt", 32'(cnt_o[1]), 14);
        check("hold tc", 32'(tc_o[1]), 0);
        step();
      end
      drv(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("wrap cnt", 32'(cnt_o[1]), 32'((2 - k + MOD) % MOD));
      check("wrap tc", 32'(tc_o[1]), 32'(k == 13));
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wrap done", 32'(done_o[1]), 1);
    step();

    // Reset while running.
    drv(1, 1, 9, 1, 0, 1, 0); step();
    drv(1, 0, 0, 0, 0, 1, 0); step(); step();
    rst = 1'b1; drv(0, 0, 0, 0, 0, 0, 0); step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst cnt", 32'(cnt_o[0]), 15);
    check("midrst busy", 32'(busy_o[0]), 0);
    check("midrst cnt1", 32'(cnt_o[1]), 15);
    step();

    // Period with reload 1 (prescaled when the option is built in).
    drv(1, 1, 1, 1, 0, 1, 0); step();
    pulses = 0; first = -1; second = -1;
    for (int k = 0; k < 32; k++) begin
      drv(1, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      if (tc_p) begin
        pulses++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      step();
    end
    check("presc pulses", 32'(pulses), 32'(32 / (2 * PRESC_T)));
    check("presc spacing", 32'(second - first), 32'(2 * PRESC_T));

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      ena      = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 9) == 0);
      d        = 4'($urandom_range(0, 15));
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 19) == 0);
      periodic = 1'($urandom_range(0, 1));
      irq_ack  = ($urandom_range(0, 7) == 0);
      step();
    end
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_descendente_recarga.md
Name: contador_descendente_recarga

Overview:
- Programmable down-counting timer; the complement of the team's loadable up-counter.
- Counts a reloadable value down to a terminal value on enabled ticks.
- Supports one-shot and periodic modes, with a sticky interrupt flag and acknowledge.
- Used as a timeout/period generator beside the up-counters in the Contadores block set.

Parameters:
- WIDTH, 32, counter/reload width in bits.
- RELOAD, 2**WIDTH-1, reset value of the reload register and of the count.
- TO, 0, terminal count value.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  count tick enable; counter only moves when high.
- load  in  1  write d into the reload register.
- d  in  WIDTH  reload value.
- start  in  1  start or restart counting from the reload value.
- stop  in  1  halt counting, holding the count.
- periodic  in  1  1 = auto-reload at terminal count, 0 = one-shot; sampled at terminal count.
- irq_ack  in  1  clear irq.
- tc  out  1  terminal-count pulse (combinational).
- irq  out  1  sticky flag, set by tc.
- busy  out  1  state==RUN.
- done  out  1  state==DONE (one-shot expired).
- cnt  out  WIDTH  current count.

Behaviour:
- Reset (rst=1 at posedge): r=RELOAD, reload_r=RELOAD, state=IDLE, irq=0. Consequently tc=0, busy=0, done=0, cnt=RELOAD. Reset dominates every other input, including mid-count.
- State machine: IDLE, RUN, DONE.
- load:
  - In any state, reload_r<=d.
  - In IDLE or DONE, r<=d as well.
  - In RUN, r is untouched; the new value takes effect at the next reload or start (shadow register).
- start, in any state when stop=0:
  - r<=reload value, state<=RUN.
  - If load is also high, the reload value is d, not the old reload_r.
  - start in RUN restarts counting from the reload value.
  - start does not itself require ena.
- stop:
  - In RUN: state<=IDLE, r holds its value.
  - stop has priority over start, and over tc in the same cycle.
  - In IDLE or DONE, stop has no effect.
- RUN with ena=1 (and no stop or start):
  - If r!=TO: r<=r-1, wrapping modulo 2^WIDTH. If the reload value is below TO, the count wraps through 2^WIDTH-1 down to TO.
  - If r==TO and periodic=1: r<=reload_r (or d if load is high), stay in RUN.
  - If r==TO and periodic=0: state<=DONE, r holds TO.
- RUN with ena=0: r holds.
- tc = (state==RUN) && ena && !stop && !start && (r==TO). Same-cycle combinational, one cycle wide per terminal event.
- Reload value equal to TO in periodic mode: tc on every enabled tick.
- Period in periodic mode: (reload - TO + 1) enabled ticks, modulo 2^WIDTH.
- irq:
  - Set on the clock edge where tc=1; cleared by irq_ack.
  - If tc and irq_ack are high in the same cycle, set wins (irq stays 1).
- Latency:
  - start → busy=1 one cycle later.
  - First decrement on the first ena cycle after busy=1.

Optional Feature:
- Macro: CONTADOR_DESCENDENTE_PRESCALER_EN.
- Defined:
  - Adds parameter PRESC (default 1, minimum 1).
  - ena feeds a prescaler; the counter's effective tick is every PRESC-th ena cycle while in RUN.
  - tc uses the effective tick in place of ena.
  - The prescaler clears on rst, start and stop.
- Undefined: the effective tick is ena directly; no prescaler logic or PRESC parameter exists.

Decomposition:
- Shared package/include (contadores_pkg):
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - A common width default constant for the Contadores family.
- Natural sub-module: prescaler_tick (WIDTH/PRESC-parameterised enable divider with sync clear), instantiated only under the macro.

Test Plan:
- Reset, then read outputs: cnt=RELOAD, busy=0, done=0, irq=0, tc=0. Then assert rst while in RUN: next cycle state IDLE, cnt=RELOAD.
- load d=3, start, periodic=0, ena=1 continuous: cnt 3,2,1,0; tc high exactly while cnt=0; then done=1, cnt stays 0, irq=1; irq_ack clears irq.
- load d=2, periodic=1, start, ena=1 for 9 cycles: tc every 3rd enabled cycle (3 pulses). Load d=5 mid-run: the next period after tc is 6 ticks, and cnt is not disturbed before tc.
- RUN at cnt=0 with ena=1, stop=1 in the same cycle: tc=0, irq unchanged, state IDLE, cnt=0. Separately, tc and irq_ack in the same cycle: irq=1 afterwards.
- TO=5, load d=2, start, ena=1: cnt wraps 2,1,0,2^WIDTH-1,... Bench with WIDTH=4: 2,1,0,15..5, tc at 5. Also ena toggled 1-0-1: count holds during 0.
- With CONTADOR_DESCENDENTE_PRESCALER_EN, PRESC=4, d=1, periodic=1: tc once per 8 ena cycles. Without the macro: same stimulus gives tc once per 2 ena cycles.
